// File: rtl/file_log_arbiter_if.sv
// Requester and file-datapath signals shared between the logging arbiter and its environment.
// The arbiter takes the master modport: it drives grants and masters the command bus.
interface file_log_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int OW   = 16
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [OW-1:0]      cmd_offset;
  logic [DW-1:0]      cmd_data;
  logic [SW-1:0]      cmd_src;
  logic               cmd_ready;
  logic [31:0]        rec_count;
  logic               finish;

  modport master (
    input  req_valid, req_data, cmd_ready,
    output req_ready, cmd_valid, cmd_op, cmd_offset, cmd_data, cmd_src, rec_count, finish
  );

  modport slave (
    output req_valid, req_data, cmd_ready,
    input  req_ready, cmd_valid, cmd_op, cmd_offset, cmd_data, cmd_src, rec_count, finish
  );
endinterface

// File: rtl/file_log_arbiter.sv
// Round-robin arbiter sharing one file-logging command port; each grant issues SEEK/WRITE/FLUSH
// into the requester's circular region and a sticky finish stops everything after MAX_RECORDS.
module file_log_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 32,
  parameter int OW           = 16,
  parameter int RECORD_BYTES = 16,
  parameter int REGION_RECS  = 8,
  parameter int MAX_RECORDS  = 11
) (
  input  logic                clk,
  input  logic                rst,
  file_log_arbiter_if.master  bus,
  output logic [2:0]          o_dbg_state
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (REGION_RECS > 1) ? $clog2(REGION_RECS) : 1;

  localparam logic [1:0] OP_SEEK  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEEK  = 3'd1,
    WRITE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_idx [NREQ];
  logic [31:0]     r_rec_count;
  logic            r_finish;
  logic [NREQ-1:0] r_req_ready;
  logic            r_cmd_valid;
  logic [1:0]      r_cmd_op;
  logic [OW-1:0]   r_cmd_offset;
  logic [DW-1:0]   r_cmd_data;
  logic [SW-1:0]   r_cmd_src;
  logic [DW-1:0]   r_payload;

  logic            w_found;
  logic [SW-1:0]   w_grant;
  logic [SW-1:0]   w_j;
  logic [SW-1:0]   w_next_rr;
  logic [31:0]     w_seek_full;
  logic [OW-1:0]   w_seek_off;

  // Handshake: a command transfers on every edge where cmd_valid && cmd_ready; while cmd_ready
  // is low the command is held unchanged. req_ready is a single-cycle accept pulse, no back-pressure.

  // Search starts at the round-robin pointer and wraps, so the first hit is the fair choice.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = SW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_j]) begin
        w_found = 1'b1;
        w_grant = w_j;
      end
    end
  end

  assign w_next_rr   = (w_grant == SW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
  assign w_seek_full = (32'(w_grant) * 32'(REGION_RECS) + 32'(r_idx[w_grant])) * 32'(RECORD_BYTES);
  assign w_seek_off  = w_seek_full[OW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_rec_count  <= '0;
      r_finish     <= 1'b0;
      r_req_ready  <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_op     <= OP_SEEK;
      r_cmd_offset <= '0;
      r_cmd_data   <= '0;
      r_cmd_src    <= '0;
      r_payload    <= '0;
      for (int i = 0; i < NREQ; i++) r_idx[i] <= '0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        IDLE: begin
          if (!r_finish && w_found) begin
            r_payload             <= bus.req_data[int'(w_grant)*DW +: DW];
            r_req_ready[w_grant]  <= 1'b1;
            r_rr_ptr              <= w_next_rr;
            r_cmd_src             <= w_grant;
            r_cmd_valid           <= 1'b1;
            r_cmd_op              <= OP_SEEK;
            r_cmd_offset          <= w_seek_off;
            r_cmd_data            <= '0;
            r_state               <= SEEK;
          end
        end
        SEEK: begin
          if (bus.cmd_ready) begin
            r_cmd_op     <= OP_WRITE;
            r_cmd_offset <= '0;
            r_cmd_data   <= r_payload;
            r_state      <= WRITE;
          end
        end
        WRITE: begin
          if (bus.cmd_ready) begin
            r_cmd_op   <= OP_FLUSH;
            r_cmd_data <= '0;
            r_state    <= FLUSH;
          end
        end
        FLUSH: begin
          if (bus.cmd_ready) begin
            r_rec_count      <= r_rec_count + 32'd1;
            r_idx[r_cmd_src] <= (r_idx[r_cmd_src] == IW'(REGION_RECS - 1)) ? '0
                                                                           : r_idx[r_cmd_src] + 1'b1;
            r_cmd_valid      <= 1'b0;
            r_cmd_op         <= OP_SEEK;
            r_cmd_src        <= '0;
            if (r_rec_count + 32'd1 == 32'(MAX_RECORDS)) begin
              r_finish <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        DONE: begin
          r_cmd_valid <= 1'b0;
          r_cmd_op    <= OP_SEEK;
          r_cmd_src   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.cmd_valid  = r_cmd_valid;
  assign bus.cmd_op     = r_cmd_op;
  assign bus.cmd_offset = r_cmd_offset;
  assign bus.cmd_data   = r_cmd_data;
  assign bus.cmd_src    = r_cmd_src;
  assign bus.rec_count  = r_rec_count;
  assign bus.finish     = r_finish;
  assign o_dbg_state    = r_state;
endmodule
